// File: rtl/slot_irq_pkg.sv
// Shared constants, FSM state type and vector formatting for the slot interrupt controller.
package slot_irq_pkg;

  localparam int N_SLOTS_DEF = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int IDX_W       = 3;

  localparam logic [7:0] MASK_BASE   = 8'h20;
  localparam logic [7:0] PEND_BASE   = 8'h28;
  localparam logic [7:0] VECTOR_ADDR = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ASSERT,
    ST_ACK
  } state_e;

  function automatic logic [15:0] vector_word(input logic valid, input logic [IDX_W-1:0] idx);
    return {valid, 11'b0, 1'b0, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting slot at or after ptr+1, wrapping.
module rr_arbiter
  import slot_irq_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF
) (
  input  logic [N_SLOTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam int unsigned N_U = N_SLOTS;

  int unsigned ptr_u;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    ptr_u     = 32'(ptr);
    // Offset i = 1 visits ptr+1 first; i = N_U wraps back to ptr itself last.
    for (int unsigned i = 1; i <= N_U; i++) begin
      for (int unsigned k = 0; k < N_U; k++) begin
        if (!gnt_valid && req[k] && (k == (ptr_u + i) % N_U)) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/slot_irq_ctrl.sv
// Slot change interrupt controller: per-slot any-edge detect, mask/pending registers,
// round-robin vectoring FSM and a registered read port for the SPI register slave.
module slot_irq_ctrl
  import slot_irq_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_SLOTS*DATA_W-1:0] slot_in,
  input  logic                      bus_we,
  input  logic                      bus_re,
  input  logic [ADDR_W-1:0]         bus_addr,
  input  logic [DATA_W-1:0]         bus_wdata,
  output logic [DATA_W-1:0]         bus_rdata,
  output logic                      bus_rvalid,
  output logic                      irq
);

  localparam int unsigned N_U = N_SLOTS;

  logic [N_SLOTS*DATA_W-1:0] slot_prev_q, slot_prev_d;
  logic [N_SLOTS*DATA_W-1:0] chg;
  logic                      primed_q, primed_d;
  logic [DATA_W-1:0]         mask_q [N_SLOTS];
  logic [DATA_W-1:0]         mask_d [N_SLOTS];
  logic [DATA_W-1:0]         pend_q [N_SLOTS];
  logic [DATA_W-1:0]         pend_d [N_SLOTS];
  logic [N_SLOTS-1:0]        mask_hit, pend_hit, active;
  logic                      vec_hit, vec_read, vec_valid;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          vec_idx_q, vec_idx_d;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      gnt_valid;
  logic                      granted_active;

  logic [DATA_W-1:0]         rd_word;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;

  always_comb begin : addr_decode
    mask_hit = '0;
    pend_hit = '0;
    for (int unsigned k = 0; k < N_U; k++) begin
      mask_hit[k] = (bus_addr == ADDR_W'(32'(MASK_BASE) + k));
      pend_hit[k] = (bus_addr == ADDR_W'(32'(PEND_BASE) + k));
    end
    vec_hit  = (bus_addr == ADDR_W'(VECTOR_ADDR));
    vec_read = bus_re && vec_hit;
  end

  // The edge register holds 0 out of reset, so the first compare after release is suppressed.
  assign chg = (slot_in ^ slot_prev_q) & {(N_SLOTS*DATA_W){primed_q}};

  always_comb begin : reg_next
    slot_prev_d = slot_in;
    primed_d    = 1'b1;
    for (int unsigned k = 0; k < N_U; k++) begin
      mask_d[k] = mask_q[k];
      if (bus_we && mask_hit[k]) begin
        mask_d[k] = bus_wdata;
      end
      pend_d[k] = pend_q[k];
      if (bus_we && pend_hit[k]) begin
        pend_d[k] = pend_q[k] & ~bus_wdata;
      end
      // OR-ing the new edges in after the clear lets a same-cycle set win.
      pend_d[k] = pend_d[k] | (chg[k*DATA_W +: DATA_W] & mask_q[k]);
    end
  end

  always_comb begin : slot_active
    active = '0;
    for (int unsigned k = 0; k < N_U; k++) begin
      active[k] = |(pend_q[k] & mask_q[k]);
    end
  end

  rr_arbiter #(
    .N_SLOTS (N_SLOTS)
  ) u_arb (
    .req       (active),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin : granted_lookup
    granted_active = 1'b0;
    for (int unsigned k = 0; k < N_U; k++) begin
      if (vec_idx_q == IDX_W'(k)) begin
        granted_active = active[k];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin : fsm_state
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    ptr_d     = ptr_q;
    vec_idx_d = vec_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|active) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (gnt_valid) begin
          vec_idx_d = gnt_idx;
          state_d   = ST_ASSERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (vec_read) begin
          state_d = ST_ACK;
        end else if (!granted_active) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!granted_active) begin
          ptr_d   = vec_idx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    irq       = (state_q == ST_ASSERT) || (state_q == ST_ACK);
    vec_valid = irq;
  end

  always_comb begin : read_mux
    rd_word = '0;
    for (int unsigned k = 0; k < N_U; k++) begin
      if (mask_hit[k]) rd_word = mask_q[k];
      if (pend_hit[k]) rd_word = pend_q[k];
    end
    if (vec_hit) begin
      rd_word = vec_valid ? DATA_W'(vector_word(1'b1, vec_idx_q)) : '0;
    end
    rdata_d  = bus_re ? rd_word : rdata_q;
    rvalid_d = bus_re;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin : regs
    if (!sys_rst_n) begin
      slot_prev_q <= '0;
      primed_q    <= 1'b0;
      for (int unsigned k = 0; k < N_U; k++) begin
        mask_q[k] <= '0;
        pend_q[k] <= '0;
      end
      ptr_q     <= IDX_W'(N_SLOTS - 1);
      vec_idx_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      slot_prev_q <= slot_prev_d;
      primed_q    <= primed_d;
      for (int unsigned k = 0; k < N_U; k++) begin
        mask_q[k] <= mask_d[k];
        pend_q[k] <= pend_d[k];
      end
      ptr_q     <= ptr_d;
      vec_idx_q <= vec_idx_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;

endmodule

// File: doc/slot_irq_ctrl.md
SLOT_IRQ_CTRL -- requirements
Module: slot_irq_ctrl

Interface
REQ-001 Parameter N_SLOTS, default 8, number of 16-bit slots served; values 1..8 only.
REQ-002 Parameter DATA_W, default 16, width of each slot and of the register-bus data.
REQ-003 Parameter ADDR_W, default 8, register-bus address width.
REQ-004 sys_clk  in  1  single clock for all logic; reset is asynchronous and active-low.
REQ-005 sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 slot_in  in  N_SLOTS*DATA_W  slot input levels, already synchronised to sys_clk; slot k is bits [16k+15:16k].
REQ-007 bus_we  in  1  one-cycle write strobe from the SPI register slave.
REQ-008 bus_re  in  1  one-cycle read strobe from the SPI register slave.
REQ-009 bus_addr  in  ADDR_W  register address; sampled when bus_we or bus_re is high.
REQ-010 bus_wdata  in  DATA_W  write data; sampled with bus_we.
REQ-011 bus_rdata  out  DATA_W  read data.
REQ-012 bus_rvalid  out  1  high for one cycle when bus_rdata is valid.
REQ-013 irq  out  1  interrupt request to the host (user_led line).

Function
REQ-014 Register map: 0x20+k MASK[k] R/W; 0x28+k PEND[k] read, write-1-to-clear; 0x30 VECTOR read-only; all other addresses are ignored on write and read as 0x0000.
REQ-015 Any-edge detect: per bit, chg = slot_in XOR slot_in registered one cycle earlier; the registered copy loads slot_in every cycle.
REQ-016 PEND[k] bit sets when chg AND MASK[k]; when set and write-1-to-clear hit the same bit in the same cycle, the set wins.
REQ-017 Writing MASK does not alter PEND; clearing a MASK bit stops new sets only.
REQ-018 Slot k is active when (PEND[k] AND MASK[k]) is non-zero.
REQ-019 FSM states IDLE, ARB, ASSERT, ACK.
REQ-020 IDLE -> ARB when any slot is active.
REQ-021 ARB lasts exactly one cycle: a round-robin choice starting at ptr+1 latches slot index into VECTOR, then -> ASSERT.
REQ-022 ASSERT drives irq=1; a VECTOR read -> ACK.
REQ-023 ACK holds irq=1 until the granted slot is no longer active, then sets ptr = granted index and goes -> IDLE; irq drops in the cycle IDLE is entered.
REQ-024 If the granted slot stops being active while in ASSERT (cleared without a VECTOR read), the FSM goes -> IDLE without updating ptr.
REQ-025 VECTOR = {valid, 11'b0, 1'b0, idx[2:0]}, valid bit at [15]; valid=1 only in ASSERT or ACK, otherwise 0x0000.
REQ-026 Read latency: bus_rdata and bus_rvalid are registered, one cycle after bus_re; bus_rdata holds its value between reads.
REQ-027 A simultaneous bus_we and bus_re executes the write, and the read returns pre-write contents.
REQ-028 Worst-case irq latency from a slot_in edge is 3 cycles: edge register, PEND set, ARB.

Reset
REQ-029 Asserting sys_rst_n low asynchronously sets the following to zero: MASK, PEND, edge register, ptr=N_SLOTS-1, VECTOR, bus_rdata, bus_rvalid, irq; state=IDLE.
REQ-030 The edge register loads slot_in on the first clock after reset release, and no PEND bit sets on that clock.
REQ-031 Reset mid-transaction discards any pending read response, and bus_rvalid is not pulsed.

Structure
REQ-032 Package slot_irq_pkg holds the following shared items: the address constants (MASK_BASE 0x20, PEND_BASE 0x28, VECTOR_ADDR 0x30), the FSM state enum, and defaults for N_SLOTS and DATA_W.
REQ-033 Sub-module rr_arbiter holds the round-robin choice; it is combinational, with inputs req[N_SLOTS-1:0] and ptr, and outputs gnt_idx and gnt_valid.

Verification
REQ-034 Write MASK[0]=0xFFFF, then toggle slot0 bit0 0->1 -> PEND[0] reads 0x0001, irq=1 within 3 cycles, VECTOR reads 0x8000.
REQ-035 After REQ-034, read VECTOR then write 0x28=0x0001 -> PEND[0]=0x0000, irq=0, VECTOR=0x0000.
REQ-036 Set MASK[2] and MASK[5]=0xFFFF, toggle both slots in the same cycle, ptr=7 -> first VECTOR 0x8002; after clearing slot 2, second VECTOR 0x8005.
REQ-037 Toggle slot0 bit3 in the same cycle as a write 0x28=0x0008 -> PEND[0] bit3 stays 1.
REQ-038 Set MASK[1]=0x0000 and toggle slot1 -> PEND[1]=0x0000 and irq stays 0; then set MASK[1]=0x00FF -> PEND is unchanged.
REQ-039 With irq=1, pulse sys_rst_n low for 5 ns -> irq, VECTOR and all PEND/MASK are 0 immediately, and there is no spurious irq after release.
